// File: rtl/sensor_bus_arbiter.sv
// Round-robin arbiter that shares one DHT11 read engine among NUM_REQ requesters.
// Each read is bounded by a timeout, and a guard interval follows every response.
module sensor_bus_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 5,
    parameter int TIMEOUT_CYCLES = 240,
    parameter int GUARD_CYCLES   = 9600
) (
    input  logic                      clk_9600hz,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         sensor_sel,
    output logic                      start_sensor,
    input  logic                      sensor_done,
    input  logic                      sensor_error,
    input  logic [0:39]               sensor_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [0:39]               rsp_data,
    output logic                      rsp_error,
    output logic                      rsp_timeout,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GRD_W = $clog2(GUARD_CYCLES + 2);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;
    localparam logic [1:0] S_GUARD   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [GRD_W-1:0]   guard_q, guard_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic               start_sensor_q, start_sensor_d;
    logic [ADDR_W-1:0]  sensor_sel_q, sensor_sel_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [0:39]        rsp_data_q, rsp_data_d;
    logic               rsp_error_q, rsp_error_d;
    logic               rsp_timeout_q, rsp_timeout_d;
    logic               busy_q, busy_d;

    logic               found;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W:0]     cand;

    // First pending requester at or above ptr, wrapping past NUM_REQ-1.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
            if (!found && req_valid[cand[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        owner_d        = owner_q;
        timer_d        = timer_q;
        guard_d        = guard_q;
        req_ready_d    = '0;
        start_sensor_d = 1'b0;
        sensor_sel_d   = sensor_sel_q;
        rsp_valid_d    = '0;
        rsp_data_d     = rsp_data_q;
        rsp_error_d    = rsp_error_q;
        rsp_timeout_d  = rsp_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d        = S_WAIT;
                    req_ready_d    = NUM_REQ'(1) << winner;
                    start_sensor_d = 1'b1;
                    sensor_sel_d   = req_addr[int'(winner)*ADDR_W +: ADDR_W];
                    owner_d        = winner;
                    ptr_d          = (winner == PTR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
                    timer_d        = '0;
                end
            end
            S_WAIT: begin
                // The timer starts counting once the start pulse cycle is over.
                if (!start_sensor_q) timer_d = timer_q + 1'b1;
                if (sensor_done) begin
                    state_d       = S_RESPOND;
                    rsp_valid_d   = NUM_REQ'(1) << owner_q;
                    rsp_data_d    = sensor_data;
                    rsp_error_d   = sensor_error;
                    rsp_timeout_d = 1'b0;
                end else if (!start_sensor_q && timer_q == TMR_W'(TIMEOUT_CYCLES-1)) begin
                    state_d       = S_RESPOND;
                    rsp_valid_d   = NUM_REQ'(1) << owner_q;
                    rsp_data_d    = '0;
                    rsp_error_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end
            S_RESPOND: begin
                if (GUARD_CYCLES == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GUARD;
                    guard_d = GRD_W'(GUARD_CYCLES);
                end
            end
            default: begin
                guard_d = guard_q - 1'b1;
                if (guard_q <= GRD_W'(1)) state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_9600hz or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            owner_q        <= '0;
            timer_q        <= '0;
            guard_q        <= '0;
            req_ready_q    <= '0;
            start_sensor_q <= 1'b0;
            sensor_sel_q   <= '0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
            rsp_error_q    <= 1'b0;
            rsp_timeout_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            owner_q        <= owner_d;
            timer_q        <= timer_d;
            guard_q        <= guard_d;
            req_ready_q    <= req_ready_d;
            start_sensor_q <= start_sensor_d;
            sensor_sel_q   <= sensor_sel_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_error_q    <= rsp_error_d;
            rsp_timeout_q  <= rsp_timeout_d;
            busy_q         <= busy_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign start_sensor = start_sensor_q;
    assign sensor_sel   = sensor_sel_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_error    = rsp_error_q;
    assign rsp_timeout  = rsp_timeout_q;
    assign busy         = busy_q;

endmodule

// File: doc/sensor_bus_arbiter.md
# sensor_bus_arbiter

Shares the single DHT11 read engine (start_sensor / sensor_data handshake) among up to NUM_REQ requesters, e.g. several UART command controllers and a periodic poller. It arbitrates round-robin, drives the sensor select address, pulses the read start, and bounds each read with a timeout. It returns the 40-bit frame and status to the winning requester, then enforces a guard interval, because DHT11 parts need about 1 s between reads.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 5, sensor select width
- TIMEOUT_CYCLES, 240, max cycles from start pulse to sensor_done (25 ms at 9600 Hz)
- GUARD_CYCLES, 9600, idle cycles after each response before the next grant (0 = none)

- clk_9600hz  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  request i pending
- req_addr  in  NUM_REQ*ADDR_W  address of requester i in bits [i*ADDR_W +: ADDR_W]
- req_ready  out  NUM_REQ  one-hot, one-cycle grant/accept pulse
- sensor_sel  out  ADDR_W  address of sensor being read
- start_sensor  out  1  one-cycle read start pulse to read engine
- sensor_done  in  1  read engine finished (one-cycle pulse)
- sensor_error  in  1  checksum/line error, valid with sensor_done
- sensor_data  in  [0:39]  raw frame, bit 0 first on the wire, valid with sensor_done
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse to owner
- rsp_data  out  [0:39]  frame returned with rsp_valid
- rsp_error  out  1  sensor_error OR timeout, valid with rsp_valid
- rsp_timeout  out  1  read timed out, valid with rsp_valid
- busy  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, WAIT, RESPOND, GUARD. All outputs are registered.
- IDLE: if any req_valid, the winner is the first set bit searching from ptr upward with wrap. In the next cycle, req_ready[winner]=1 and start_sensor=1 for exactly one cycle. sensor_sel loads req_addr[winner], owner and ptr update (ptr=winner+1 mod NUM_REQ), the timer clears, and the FSM enters WAIT.
- Requesters hold req_valid/req_addr stable until req_ready. Dropping req_valid before the grant withdraws the request without error. req_valid is sampled only in IDLE.
- WAIT: the timer increments each cycle.
  - On sensor_done: latch sensor_data and sensor_error, set rsp_timeout=0, go to RESPOND.
  - Else, when the timer reaches TIMEOUT_CYCLES-1: rsp_data=0, rsp_error=1, rsp_timeout=1, go to RESPOND.
  - If sensor_done arrives on the timeout cycle, done wins.
- RESPOND: rsp_valid[owner]=1 for one cycle. Load the guard counter with GUARD_CYCLES and go to GUARD, or to IDLE if GUARD_CYCLES=0.
- GUARD: count down to zero, then go to IDLE. Requests stay pending and are not granted.
- Signal hold behaviour:
  - sensor_done and sensor_error are ignored outside WAIT.
  - sensor_sel holds until the next grant.
  - rsp_data, rsp_error and rsp_timeout hold until the next RESPOND.
- A requester may re-request immediately after rsp_valid. It competes normally, with lowest priority due to the pointer.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, ptr=0, and every output is 0: req_ready, start_sensor, sensor_sel, rsp_valid, rsp_data, rsp_error, rsp_timeout, busy.
- After release, the first grant goes to the lowest-index active requester.
- Grant latency: req_valid seen in IDLE at edge N gives req_ready and start_sensor high during cycle N+1, with busy=1 from N+1.
- Response latency: sensor_done sampled at edge M gives rsp_valid during cycle M+1.
- Timeout: rsp_valid is asserted TIMEOUT_CYCLES+1 cycles after the start_sensor cycle.
- Minimum spacing between start_sensor pulses: 3 + GUARD_CYCLES + response time.
- Reset mid-operation (any state) aborts the read. A late sensor_done after reset release lands in IDLE and is ignored. No rsp_valid is issued for the aborted read.

## Test plan
- Reset: hold reset=0 with req_valid=4'b1111 and sensor_done toggling -> all outputs 0, busy=0, no start_sensor.
- Single read (GUARD_CYCLES=16): req_valid[2]=1, req_addr[2]=5'd5; sensor_done after 50 cycles with sensor_data=40'h3500_1A00_4F, error=0 -> req_ready=4'b0100 and start_sensor in the same cycle, sensor_sel=5, rsp_valid=4'b0100 one cycle after done, rsp_data=40'h3500_1A00_4F, rsp_error=0, busy low 17 cycles later.
- Round-robin: req_valid=4'b1111 held, engine answers after 10 cycles -> grant order 0,1,2,3,0, with start pulses at least 16+13 cycles apart.
- Timeout: one request, sensor_done never asserted -> rsp_valid at start+241, rsp_timeout=1, rsp_error=1, rsp_data=0.
- Simultaneous done/timeout: sensor_done on timer=239 with error=1 -> rsp_timeout=0, rsp_error=1, rsp_data = the sensor_data supplied with that sensor_done.
- Abort: reset=0 for one cycle mid-WAIT, then sensor_done -> no rsp_valid; with req_valid=4'b1010, the next grant is requester 1.
